z80_busrq_dma_ctrl: RTL and testbench

//  Bus-request DMA sequencer for the tv80s system bus. On start it raises BUSRQ to the CPU and waits for BUSAK.
//  It then copies LEN bytes from SRC to DST in the shared 64K memory, one read cycle and one write cycle per byte.
//  It gives the bus back to the CPU every BURST bytes so that the CPU keeps running.

---
 rtl/z80_dma_pkg.sv | 22 ++
 rtl/z80_dma_addr_gen.sv | 53 +++++
 rtl/z80_busrq_dma_ctrl.sv | 162 ++++++++++++++++
 tb/tb_z80_busrq_dma_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_dma_pkg.sv
// Shared types and defaults for the tv80s bus-request DMA sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package z80_dma_pkg;

    // Sequencer states: one read address cycle, one read data cycle and one write cycle per byte.
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD_A,
        RD_D,
        WR,
        GAP,
        FIN
    } dma_state_t;

    // Bytes per bus tenure (0 keeps the bus until the whole copy is done).
    localparam int DMA_BURST_DEF = 16;
    // Clocks with BUSRQ released between tenures so the CPU can run.
    localparam int DMA_GAP_DEF   = 8;

endpackage

// File: rtl/z80_dma_addr_gen.sv
// Address/count generator: source, destination, remaining bytes and bytes-in-tenure.
// Latency: load and step take effect at the next rising edge; last/burst_end are combinational.
// Backpressure: none; the sequencer steps exactly once per written byte.
module z80_dma_addr_gen
    import z80_dma_pkg::*;
#(
    parameter int BURST = DMA_BURST_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] src_init,
    input  logic [15:0] dst_init,
    input  logic [15:0] len_init,
    output logic [15:0] src,
    output logic [15:0] dst,
    output logic        last,
    output logic        burst_end
);

    // BURST=0 wraps this to FFFF, but burst_end is gated off in that case anyway.
    localparam logic [15:0] BURST_LAST = 16'(BURST - 1);

    logic [15:0] remaining;
    logic [15:0] burst_cnt;

    // The byte being written is the final one of the copy.
    assign last      = (remaining == 16'd1);
    // The byte being written closes the current bus tenure.
    assign burst_end = (BURST != 0) && (burst_cnt == BURST_LAST);

    // Counters: latch on load, advance (with 16-bit wrap) once per written byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            src       <= 16'h0000;
            dst       <= 16'h0000;
            remaining <= 16'h0000;
            burst_cnt <= 16'h0000;
        end else if (load) begin
            src       <= src_init;
            dst       <= dst_init;
            remaining <= len_init;
            burst_cnt <= 16'h0000;
        end else if (step) begin
            src       <= src + 16'd1;
            dst       <= dst + 16'd1;
            remaining <= remaining - 16'd1;
            burst_cnt <= burst_end ? 16'h0000 : burst_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/z80_busrq_dma_ctrl.sv
// BUSRQ/BUSAK memory-to-memory copy engine sitting beside tv80s on the shared 64K bus.
// Latency: start->REQ in 1 clock; 3 clocks per byte while holding the bus; done 1 clock after the last write.
// Backpressure: waits indefinitely in REQ for BUSAK; releases the bus every BURST bytes for GAP_CYCLES clocks.
module z80_busrq_dma_ctrl
    import z80_dma_pkg::*;
#(
    parameter int BURST      = DMA_BURST_DEF,
    parameter int GAP_CYCLES = DMA_GAP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic        dma_bus_en,
    output logic [15:0] dma_a,
    output logic [7:0]  dma_do,
    input  logic [7:0]  dma_di,
    output logic        dma_mreq_n,
    output logic        dma_rd_n,
    output logic        dma_wr_n
);

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    dma_state_t  state;
    dma_state_t  next_state;
    logic        load;
    logic        step;
    logic [15:0] src;
    logic [15:0] dst;
    logic        last;
    logic        burst_end;
    logic [15:0] gap_cnt;
    logic [7:0]  data_q;

    z80_dma_addr_gen #(
        .BURST (BURST)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .src_init  (src_addr),
        .dst_init  (dst_addr),
        .len_init  (len),
        .src       (src),
        .dst       (dst),
        .last      (last),
        .burst_end (burst_end)
    );

    // State register; reset abandons any copy in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counts clocks spent in GAP; held at zero everywhere else.
    always_ff @(posedge clk) begin
        if (reset || (state != GAP)) begin
            gap_cnt <= 16'h0000;
        end else begin
            gap_cnt <= gap_cnt + 16'd1;
        end
    end

    // Read data is captured at the edge that closes RD_D and replayed during WR.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= 8'h00;
        end else if (state == RD_D) begin
            data_q <= dma_di;
        end
    end

    // Next-state and bus decode; outputs are pure functions of the state so reset clears them at once.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        busrq_n    = 1'b1;
        dma_bus_en = 1'b0;
        dma_a      = 16'h0000;
        dma_do     = 8'h00;
        dma_mreq_n = 1'b1;
        dma_rd_n   = 1'b1;
        dma_wr_n   = 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    if (len != 16'h0000) begin
                        load       = 1'b1;
                        next_state = REQ;
                    end else begin
                        // Empty copy: report completion without touching the bus.
                        next_state = FIN;
                    end
                end
            end
            REQ: begin
                busy    = 1'b1;
                busrq_n = 1'b0;
                if (!busak_n) begin
                    next_state = RD_A;
                end
            end
            RD_A, RD_D: begin
                busy       = 1'b1;
                busrq_n    = 1'b0;
                dma_bus_en = 1'b1;
                dma_a      = src;
                dma_mreq_n = 1'b0;
                dma_rd_n   = 1'b0;
                next_state = (state == RD_A) ? RD_D : WR;
            end
            WR: begin
                busy       = 1'b1;
                busrq_n    = 1'b0;
                dma_bus_en = 1'b1;
                dma_a      = dst;
                dma_do     = data_q;
                dma_mreq_n = 1'b0;
                dma_wr_n   = 1'b0;
                step       = 1'b1;
                if (last) begin
                    next_state = FIN;
                end else if (burst_end) begin
                    next_state = GAP;
                end else begin
                    next_state = RD_A;
                end
            end
            GAP: begin
                // BUSAK is not looked at here; the CPU keeps the bus until REQ asks again.
                busy = 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    next_state = REQ;
                end
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_z80_busrq_dma_ctrl.sv
// Bench for z80_busrq_dma_ctrl: behavioural CPU bus-grant model plus 64K memory, write scoreboard.
// Latency: n/a.
// Backpressure: the CPU model acknowledges BUSRQ after a random 0..2 clock delay.
module tb_z80_busrq_dma_ctrl;

    localparam int BURST = 2;
    localparam int GAP   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src_addr = 16'h0000;
    logic [15:0] dst_addr = 16'h0000;
    logic [15:0] len = 16'h0000;
    logic        busy;
    logic        done;
    logic        busrq_n;
    logic        busak_n = 1'b1;
    logic        dma_bus_en;
    logic [15:0] dma_a;
    logic [7:0]  dma_do;
    logic [7:0]  dma_di = 8'h00;
    logic        dma_mreq_n;
    logic        dma_rd_n;
    logic        dma_wr_n;

    z80_busrq_dma_ctrl #(
        .BURST      (BURST),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .busrq_n    (busrq_n),
        .busak_n    (busak_n),
        .dma_bus_en (dma_bus_en),
        .dma_a      (dma_a),
        .dma_do     (dma_do),
        .dma_di     (dma_di),
        .dma_mreq_n (dma_mreq_n),
        .dma_rd_n   (dma_rd_n),
        .dma_wr_n   (dma_wr_n)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [23:0] exp_q [$];     // {dst address, data} for every write still owed
    int          ten_q [$];     // bytes written per bus tenure
    int          gap_q [$];     // BUSRQ-high clocks between tenures of one copy
    int          n_vec = 0;
    int          n_miscmp = 0;
    int          done_cnt = 0;
    int          write_cnt = 0;
    int          tenures = 0;
    int          gap_cpu = 0;
    int          wr_in_ten = 0;
    int          gap_run = 0;
    int          lat = 0;
    int          cpu_lat = 0;
    logic        prev_busrq_n = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Memory, CPU bus-grant model and bus monitor, all evaluated on the falling edge.
    always @(negedge clk) begin
        logic [23:0] e;
        if (!dma_mreq_n && !dma_rd_n) dma_di = mem[dma_a];
        if (!dma_mreq_n && !dma_wr_n) begin
            mem[dma_a] = dma_do;
            write_cnt++;
            wr_in_ten++;
            if (exp_q.size() == 0) begin
                check_val("write with empty scoreboard", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("write address", {16'h0, dma_a}, {16'h0, e[23:8]});
                check_val("write data", {24'h0, dma_do}, {24'h0, e[7:0]});
            end
        end
        if (reset) begin
            busak_n = 1'b1;
            lat     = 0;
        end else if (!busrq_n) begin
            if (busak_n) begin
                if (lat >= cpu_lat) busak_n = 1'b0;
                else lat++;
            end
        end else begin
            busak_n = 1'b1;
            lat     = 0;
            cpu_lat = $urandom_range(0, 2);
        end
        if (busak_n && busy && busrq_n) gap_cpu++;
        if (done) done_cnt++;
        if (prev_busrq_n && !busrq_n) begin
            tenures++;
            wr_in_ten = 0;
            if (gap_run > 0) gap_q.push_back(gap_run);
            gap_run = 0;
        end
        if (!prev_busrq_n && busrq_n) ten_q.push_back(wr_in_ten);
        if (busy && busrq_n) gap_run++;
        else if (!busy) gap_run = 0;
        prev_busrq_n = busrq_n;
    end

    task automatic start_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                              input bit expect_copy);
        if (expect_copy) begin
            for (int i = 0; i < int'(n); i++) begin
                logic [15:0] sa;
                logic [15:0] da;
                sa = s + 16'(i);
                da = d + 16'(i);
                exp_q.push_back({da, mem[sa]});
            end
        end
        @(posedge clk); #1;
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        for (int i = 0; i < budget && done_cnt == base; i++) @(posedge clk);
        #1;
        check_val({tag, " done seen within budget"}, 32'(done_cnt - base > 0), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check_val({tag, " exactly one done"}, 32'(done_cnt - base), 32'd1);
        check_val({tag, " busrq_n high after done"}, {31'h0, busrq_n}, 32'd1);
        check_val({tag, " busy low after done"}, {31'h0, busy}, 32'd0);
        check_val({tag, " scoreboard drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int wbase;
        int tbase;
        int gbase;
        int cbase;
        int nseen;
        logic [7:0] t1 [4];
        logic [7:0] t4 [4];

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8));

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset busy", {31'h0, busy}, 32'd0);
        check_val("reset done", {31'h0, done}, 32'd0);
        check_val("reset busrq_n", {31'h0, busrq_n}, 32'd1);
        check_val("reset dma_bus_en", {31'h0, dma_bus_en}, 32'd0);
        check_val("reset dma_a", {16'h0, dma_a}, 32'd0);
        check_val("reset dma_do", {24'h0, dma_do}, 32'd0);
        check_val("reset strobes", {29'h0, dma_mreq_n, dma_rd_n, dma_wr_n}, 32'd7);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // 1: plain 4-byte copy
        t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33; t1[3] = 8'h44;
        for (int i = 0; i < 4; i++) mem[16'h1000 + i] = t1[i];
        base = done_cnt;
        start_xfer(16'h1000, 16'h2000, 16'd4, 1'b1);
        wait_done("t1", base, 400);
        for (int i = 0; i < 4; i++) check_val("t1 dst byte", {24'h0, mem[16'h2000 + i]}, {24'h0, t1[i]});

        // 2: zero length. start is sampled at the first edge, done is high for the
        // clock after it and has gone by the second edge; the bus is never requested.
        base  = done_cnt;
        wbase = write_cnt;
        tbase = tenures;
        @(posedge clk); #1;
        len   = 16'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("t2 done in cycle after start", {31'h0, done}, 32'd1);
        check_val("t2 busy stays low", {31'h0, busy}, 32'd0);
        check_val("t2 busrq_n high", {31'h0, busrq_n}, 32'd1);
        @(posedge clk); #1;
        check_val("t2 done gone at second edge", {31'h0, done}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check_val("t2 one done pulse", 32'(done_cnt - base), 32'd1);
        check_val("t2 no tenure", 32'(tenures - tbase), 32'd0);
        check_val("t2 no writes", 32'(write_cnt - wbase), 32'd0);

        // 3: len=5 with BURST=2 -> tenures of 2,2,1 bytes separated by GAP-clock gaps
        for (int i = 0; i < 5; i++) mem[16'h3000 + i] = 8'($urandom);
        base  = done_cnt;
        tbase = ten_q.size();
        gbase = gap_q.size();
        cbase = gap_cpu;
        start_xfer(16'h3000, 16'h4000, 16'd5, 1'b1);
        wait_done("t3", base, 400);
        check_val("t3 tenure count", 32'(ten_q.size() - tbase), 32'd3);
        if (ten_q.size() - tbase == 3) begin
            check_val("t3 tenure 1 bytes", 32'(ten_q[tbase]), 32'd2);
            check_val("t3 tenure 2 bytes", 32'(ten_q[tbase + 1]), 32'd2);
            check_val("t3 tenure 3 bytes", 32'(ten_q[tbase + 2]), 32'd1);
        end
        check_val("t3 gap count", 32'(gap_q.size() - gbase), 32'd2);
        for (int i = gbase; i < gap_q.size(); i++) check_val("t3 gap length", 32'(gap_q[i]), 32'(GAP));
        check_val("t3 cpu ran during gaps", 32'(gap_cpu - cbase >= 2), 32'd1);

        // 4: address wrap on the source side
        t4[0] = 8'hA1; t4[1] = 8'hB2; t4[2] = 8'hC3; t4[3] = 8'hD4;
        mem[16'hFFFE] = t4[0]; mem[16'hFFFF] = t4[1]; mem[16'h0000] = t4[2]; mem[16'h0001] = t4[3];
        base = done_cnt;
        start_xfer(16'hFFFE, 16'h7FFE, 16'd4, 1'b1);
        wait_done("t4", base, 400);
        for (int i = 0; i < 4; i++) check_val("t4 dst byte", {24'h0, mem[16'h7FFE + i]}, {24'h0, t4[i]});

        // 5: reset during the write of byte 2 of an 8-byte copy
        for (int i = 0; i < 8; i++) begin
            mem[16'h5000 + i] = 8'h60 + 8'(i);
            mem[16'h6000 + i] = 8'hEE;
        end
        base = done_cnt;
        start_xfer(16'h5000, 16'h6000, 16'd8, 1'b1);
        nseen = 0;
        for (int i = 0; i < 200 && nseen < 2; i++) begin
            @(posedge clk); #1;
            if (!dma_wr_n) nseen++;
        end
        check_val("t5 reached write of byte 2", 32'(nseen), 32'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("t5 busrq_n after reset", {31'h0, busrq_n}, 32'd1);
        check_val("t5 dma_bus_en after reset", {31'h0, dma_bus_en}, 32'd0);
        check_val("t5 busy after reset", {31'h0, busy}, 32'd0);
        reset = 1'b0;
        check_val("t5 writes outstanding", 32'(exp_q.size()), 32'd6);
        exp_q.delete();
        repeat (40) @(posedge clk);
        #1;
        check_val("t5 no done pulse", 32'(done_cnt - base), 32'd0);
        check_val("t5 byte 2 written", {24'h0, mem[16'h6001]}, 32'h61);
        for (int i = 2; i < 8; i++) check_val("t5 dst untouched", {24'h0, mem[16'h6000 + i]}, 32'hEE);

        // 6: second start while busy is ignored
        for (int i = 0; i < 8; i++) mem[16'h1100 + i] = 8'($urandom);
        mem[16'h2200] = 8'h5A;
        base = done_cnt;
        start_xfer(16'h1100, 16'h2100, 16'd8, 1'b1);
        repeat (4) @(posedge clk);
        start_xfer(16'h3300, 16'h2200, 16'd3, 1'b0);
        wait_done("t6", base, 600);
        check_val("t6 second dst untouched", {24'h0, mem[16'h2200]}, 32'h5A);
        for (int i = 0; i < 8; i++)
            check_val("t6 dst byte", {24'h0, mem[16'h2100 + i]}, {24'h0, mem[16'h1100 + i]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
